ram_load_writer: RTL
====================

Name: ram_load_writer

Overview:
Downstream stage of the SD-card RAM loader. It accepts 16-bit words over the loader's ram_we/ram_op_begun word handshake and buffers them in a small FIFO. It then issues them as Avalon-MM writes to the SDRAM controller, honouring waitrequest. When the loader reports done, it drains the FIFO and reports completion, so downstream consumers (video/audio readers) start only after every word is committed to SDRAM.

Parameters:
ADDR_W, 25, loader word-address width
DATA_W, 16, word width
FIFO_DEPTH, 8, buffered words (power of 2, >=2)
AVM_ADDR_W, 26, Avalon address width; byte address = word address << 1

Ports:
clk50  in  1  system clock
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
ram_we  in  1  loader write request; held until acknowledged
ram_address  in  ADDR_W  loader word address
ram_data  in  DATA_W  loader word
ram_op_begun  out  1  one-cycle acknowledge; word accepted
init_done  in  1  loader finished (level)
avm_address  out  AVM_ADDR_W  SDRAM byte address
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  write data
avm_byteenable  out  2  always 2'b11
avm_waitrequest  in  1  SDRAM stall
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
write_count  out  ADDR_W  completed Avalon writes
seq_error  out  1  sticky: non-sequential loader address seen
drain_done  out  1  sticky: all words committed after init_done

Behaviour:
- Reset (async, reset_n=0): ram_op_begun=0, avm_write=0, avm_address=0, avm_writedata=0, fifo empty, fifo_level=0, write_count=0, seq_error=0, drain_done=0, expected address=0, state=RUN. A reset mid-operation drops any in-flight write and all buffered words.
- Accept condition (edge k): ram_we=1 && !full && ram_op_begun=0 && state=RUN. At edge k: push {ram_address, ram_data}; ram_op_begun=1 during cycle k+1 only.
- The ram_op_begun=0 qualifier blocks a double accept while the loader still holds ram_we during the ack cycle. Maximum accept rate is 1 word per 2 cycles.
- Full: ack is withheld; the loader holds ram_we/address/data stable until space frees.
- Full plus pop on the same edge: no push that edge. Accept becomes possible the following cycle (full is registered).
- Sequence check: on each accept, if ram_address != expected, seq_error<=1 (sticky). The word is still written. expected <= ram_address+1.
- Avalon output stage (registered):
  - If avm_write=0 or (avm_write=1 && avm_waitrequest=0), load the stage from the FIFO head: avm_write = !empty, pop if loaded, avm_address = {addr,1'b0}.
  - While avm_write=1 && avm_waitrequest=1, all avm_* signals are held stable.
  - Write completes on an edge with avm_write=1 && avm_waitrequest=0; write_count increments (wraps modulo 2^ADDR_W; cannot wrap for a valid load).
- FSM:
  - RUN: accepts as above. init_done=1 -> FLUSH (a word accepted on the same edge is still pushed).
  - FLUSH: no accepts. When FIFO empty && avm_write=0 -> DONE.
  - DONE: drain_done=1 (sticky until reset); no accepts; avm_write=0.
- fifo_level counts FIFO entries only, excluding the output-stage word.
- Latency: accept edge -> avm_write high no earlier than 2 edges later (push, then stage load) when empty and not stalled.

Decomposition:
- Package ram_load_pkg:
  - state enum {RUN, FLUSH, DONE}
  - widths ADDR_W/DATA_W
  - fifo entry struct {addr, data}
  - BYTEEN_ALL=2'b11
- Sub-module ram_load_fifo: synchronous show-ahead FIFO, async active-low reset, push/pop/full/empty/level. The top level holds the handshake, sequence check, output stage and FSM.

Test Plan:
- Loader model writes addresses 0..15, data 16'hA000+addr, waitrequest=0 -> 16 Avalon writes at byte addresses 0,2,..,30 with matching data; one ram_op_begun pulse per word; write_count=16.
- waitrequest held 1 for 40 cycles during 20 words -> FIFO reaches 8, ram_op_begun withheld while full, avm_* stable during stall, no word lost or duplicated; write_count=20 after release.
- ram_we held 5 cycles with ack in cycle 2 -> exactly one push; fifo_level=1.
- Addresses 0,1,2,5 -> seq_error=1 after 4th accept; all 4 words written, including byte address 10.
- init_done asserted with 6 words buffered and waitrequest toggling -> state FLUSH, drain_done=1 only after the 6th write completes; ram_we afterwards never acked.
- reset_n pulsed low mid-stall with 4 words buffered -> immediately avm_write=0, fifo_level=0, write_count=0, drain_done=0; a fresh load from address 0 completes normally with seq_error=0.

Source files
------------

// File: rtl/ram_load_pkg.sv
// Shared types and widths for the SD-card RAM loader write stage.
`timescale 1ns/1ps
package ram_load_pkg;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 16;

   localparam logic [1:0] BYTEEN_ALL = 2'b11;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DONE
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/ram_load_fifo.sv
// Show-ahead FIFO: rd_data always presents the head entry while not empty.
`timescale 1ns/1ps
module ram_load_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk50,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage write; the caller never pushes while full.
   // NOTE: the array has no reset -- stale entries are unreachable because the
   // level counter is reset, and leaving it unreset lets it map onto RAM cells.
   always_ff @(posedge clk50) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level <= level + LVL_W'(push) - LVL_W'(pop);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);

endmodule

// File: rtl/ram_load_writer.sv
// Buffers loader words in a FIFO and commits them to SDRAM over Avalon-MM,
// reporting drain completion once init_done is seen and every word is written.
`timescale 1ns/1ps
module ram_load_writer #(
   parameter int ADDR_W     = ram_load_pkg::ADDR_W,
   parameter int DATA_W     = ram_load_pkg::DATA_W,
   parameter int FIFO_DEPTH = 8,
   parameter int AVM_ADDR_W = 26,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk50,
   input  logic                  reset_n,
   input  logic                  ram_we,
   input  logic [ADDR_W-1:0]     ram_address,
   input  logic [DATA_W-1:0]     ram_data,
   output logic                  ram_op_begun,
   input  logic                  init_done,
   output logic [AVM_ADDR_W-1:0] avm_address,
   output logic                  avm_write,
   output logic [DATA_W-1:0]     avm_writedata,
   output logic [1:0]            avm_byteenable,
   input  logic                  avm_waitrequest,
   output logic [LVL_W-1:0]      fifo_level,
   output logic [ADDR_W-1:0]     write_count,
   output logic                  seq_error,
   output logic                  drain_done
);

   import ram_load_pkg::*;

   localparam int ENTRY_W = ADDR_W + DATA_W;

   state_t              state;
   state_t              next_state;
   logic                accept;
   logic                load_stage;
   logic                fifo_pop;
   logic                full;
   logic                empty;
   logic [ENTRY_W-1:0]  head;
   logic [ADDR_W-1:0]   head_addr;
   logic [DATA_W-1:0]   head_data;
   logic [ADDR_W-1:0]   expected_addr;

   assign {head_addr, head_data} = head;

   // The output stage refills whenever it is idle or its write is completing.
   assign load_stage = !avm_write || !avm_waitrequest;
   assign fifo_pop   = load_stage && !empty;

   ram_load_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk50   (clk50),
      .reset_n (reset_n),
      .push    (accept),
      .pop     (fifo_pop),
      .wr_data ({ram_address, ram_data}),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   // State register.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next state and accept decision; the ack-cycle qualifier prevents a
   // second accept while the loader is still holding ram_we.
   // NOTE: every output gets a default first so no path leaves one unassigned
   // and infers a latch.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         RUN: begin
            accept = ram_we && !full && !ram_op_begun;
            if (init_done) begin
               next_state = FLUSH;
            end
         end
         FLUSH: begin
            if (empty && !avm_write) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = DONE;
         default: next_state = RUN;
      endcase
   end

   // Acknowledge pulse and loader address sequence check.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         ram_op_begun  <= 1'b0;
         expected_addr <= '0;
         seq_error     <= 1'b0;
      end else begin
         ram_op_begun <= accept;
         if (accept) begin
            expected_addr <= ram_address + ADDR_W'(1);
            if (ram_address != expected_addr) begin
               seq_error <= 1'b1;
            end
         end
      end
   end

   // Avalon output stage: held during waitrequest, refilled from the FIFO head otherwise.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         write_count   <= '0;
      end else begin
         if (load_stage) begin
            avm_write <= !empty;
            if (!empty) begin
               avm_address   <= AVM_ADDR_W'({head_addr, 1'b0});
               avm_writedata <= head_data;
            end
         end
         if (avm_write && !avm_waitrequest) begin
            write_count <= write_count + ADDR_W'(1);
         end
      end
   end

   assign avm_byteenable = BYTEEN_ALL;
   assign drain_done     = (state == DONE);

endmodule
